serial_adder: RTL

- Bit-serial, LSB-first adder built on the team's half adder cell: two half adders plus an OR form the per-bit full adder, and a carry flip-flop closes the loop.
- It is the sequential stage that feeds operand bit pairs into the half adder datapath and collects the sum bits.
- It turns two WIDTH-bit words into a WIDTH-bit sum plus carry-out over WIDTH clock cycles.
- Control uses a start/busy/done handshake.

---
 rtl/serial_adder_if.sv | 24 ++
 rtl/serial_adder.sv | 114 +++++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial adder.
// The master drives the operands; the slave (the adder) returns the result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: a full adder built from two half adder cells
// plus an OR, with a carry flip-flop closing the loop over WIDTH cycles.
module serial_adder_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] msb_s;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic             last;

    logic s0, c0, s, c1, c_next;

    serial_adder_ha u_ha0 (.x(sa[0]), .y(sb[0]), .s(s0), .c(c0));
    serial_adder_ha u_ha1 (.x(s0),    .y(c),     .s(s),  .c(c1));
    assign c_next = c0 | c1;

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    always_comb begin
        msb_s            = '0;
        msb_s[WIDTH-1]   = s;
        sr_next          = (sr >> 1) | msb_s;
    end

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sa     <= bus.a;
                        sb     <= bus.b;
                        c      <= bus.cin;
                        sr     <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    sa <= sa >> 1;
                    sb <= sb >> 1;
                    sr <= sr_next;
                    c  <= c_next;
                    // Outputs update only here, so they hold the old result during RUN.
                    if (last) begin
                        sum_q  <= sr_next;
                        cout_q <= c_next;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule
